// File: rtl/stack_pkg.sv
// Shared types and helpers for the stacking-game row driver.
package stack_pkg;

    localparam int DEF_COLS  = 8;
    localparam int DEF_ROWS  = 8;
    localparam int DEF_MAX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_CHECK = 3'd2,
        ST_NEXT  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } stack_state_t;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/block_row_driver_step_timer.sv
// Counts tick_en strobes and fires a one-cycle step every max(period,1) strobes.
module step_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_en,
    input  logic [7:0] period,
    input  logic       clear,
    input  logic       hold,
    output logic       step
);

    logic [7:0] r_count;
    logic [7:0] w_period_eff;
    logic       w_hit;

    assign w_period_eff = (period == 8'd0) ? 8'd1 : period;
    // >= rather than == so a period shortened mid-count still fires promptly
    assign w_hit = (({1'b0, r_count} + 9'd1) >= {1'b0, w_period_eff});
    assign step  = tick_en & ~hold & ~clear & w_hit;

    // Tick counter: cleared on restart/new row, frozen while held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (hold) begin
            r_count <= r_count;
        end else if (tick_en) begin
            r_count <= w_hit ? 8'd0 : (r_count + 8'd1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/block_row_driver.sv
// Active-row driver: moves the block segment, trims it on drop, and tracks
// row progress, win and game-over.
module block_row_driver
    import stack_pkg::*;
#(
    parameter  int COLS  = DEF_COLS,
    parameter  int ROWS  = DEF_ROWS,
    parameter  int MAX_W = DEF_MAX_W,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int WW    = $clog2(MAX_W + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick_en,
    input  logic [7:0]      period,
    input  logic            start,
    input  logic            drop,
    output logic [COLS-1:0] row_mask,
    output logic [COLS-1:0] base_mask,
    output logic [RW-1:0]   row_idx,
    output logic [WW-1:0]   width,
    output logic            stacked,
    output logic            game_over,
    output logic            win
);

    function automatic logic [COLS-1:0] low_ones(input logic [WW-1:0] n);
        logic [COLS-1:0] v;
        for (int i = 0; i < COLS; i++) begin
            v[i] = (32'(i) < 32'(n));
        end
        return v;
    endfunction

    stack_state_t    r_state,     w_state_nxt;
    logic [COLS-1:0] r_row_mask,  w_row_mask_nxt;
    logic [COLS-1:0] r_base_mask, w_base_mask_nxt;
    logic [RW-1:0]   r_row_idx,   w_row_idx_nxt;
    logic [WW-1:0]   r_width,     w_width_nxt;
    logic            r_stacked,   w_stacked_nxt;
    logic            r_game_over, w_game_over_nxt;
    logic            r_win,       w_win_nxt;
    logic            r_dir_up,    w_dir_up_nxt;

    logic            w_start_ok;
    logic            w_hold;
    logic            w_clear;
    logic            w_step;
    logic [COLS-1:0] w_overlap;
    logic [5:0]      w_overlap_cnt;
    logic [COLS-1:0] w_low_mask;
    logic [COLS-1:0] w_init_mask;
    logic            w_full_width;
    logic            w_last_row;

    assign w_start_ok    = start & ((r_state == ST_IDLE) | (r_state == ST_OVER) | (r_state == ST_WIN));
    assign w_hold        = (r_state != ST_MOVE) | drop;
    assign w_clear       = w_start_ok | (r_state == ST_NEXT);
    assign w_overlap     = r_row_mask & r_base_mask;
    assign w_overlap_cnt = popcount(32'(w_overlap));
    assign w_low_mask    = low_ones(r_width);
    assign w_init_mask   = low_ones(WW'(MAX_W));
    assign w_full_width  = (32'(r_width) == 32'(COLS));
    assign w_last_row    = (32'(r_row_idx) == 32'(ROWS - 1));

    step_timer u_step_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_en (tick_en),
        .period  (period),
        .clear   (w_clear),
        .hold    (w_hold),
        .step    (w_step)
    );

    // Next-state and next-output logic for the game FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_row_mask_nxt  = r_row_mask;
        w_base_mask_nxt = r_base_mask;
        w_row_idx_nxt   = r_row_idx;
        w_width_nxt     = r_width;
        w_stacked_nxt   = 1'b0;
        w_game_over_nxt = r_game_over;
        w_win_nxt       = r_win;
        w_dir_up_nxt    = r_dir_up;

        case (r_state)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (w_start_ok) begin
                    w_row_idx_nxt   = '0;
                    w_base_mask_nxt = '1;
                    w_width_nxt     = WW'(MAX_W);
                    w_row_mask_nxt  = w_init_mask;
                    w_dir_up_nxt    = 1'b1;
                    w_game_over_nxt = 1'b0;
                    w_win_nxt       = 1'b0;
                    w_state_nxt     = ST_MOVE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_MOVE: begin
                if (drop) begin
                    w_state_nxt = ST_CHECK;
                end else if (w_step && !w_full_width) begin
                    // Reaching an edge reverses direction within the same step
                    if (r_dir_up) begin
                        if (r_row_mask[COLS-1]) begin
                            w_dir_up_nxt   = 1'b0;
                            w_row_mask_nxt = {1'b0, r_row_mask[COLS-1:1]};
                        end else begin
                            w_row_mask_nxt = {r_row_mask[COLS-2:0], 1'b0};
                        end
                    end else begin
                        if (r_row_mask[0]) begin
                            w_dir_up_nxt   = 1'b1;
                            w_row_mask_nxt = {r_row_mask[COLS-2:0], 1'b0};
                        end else begin
                            w_row_mask_nxt = {1'b0, r_row_mask[COLS-1:1]};
                        end
                    end
                end else begin
                    w_state_nxt = ST_MOVE;
                end
            end
            ST_CHECK: begin
                if (w_overlap == '0) begin
                    w_game_over_nxt = 1'b1;
                    w_row_mask_nxt  = '0;
                    w_state_nxt     = ST_OVER;
                end else begin
                    w_row_mask_nxt = w_overlap;
                    w_width_nxt    = WW'(w_overlap_cnt);
                    w_stacked_nxt  = 1'b1;
                    if (w_last_row) begin
                        w_win_nxt   = 1'b1;
                        w_state_nxt = ST_WIN;
                    end else begin
                        w_state_nxt = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                w_base_mask_nxt = r_row_mask;
                w_row_idx_nxt   = r_row_idx + RW'(1);
                w_row_mask_nxt  = w_low_mask;
                w_dir_up_nxt    = 1'b1;
                w_state_nxt     = ST_MOVE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_row_mask  <= '0;
            r_base_mask <= '1;
            r_row_idx   <= '0;
            r_width     <= WW'(MAX_W);
            r_stacked   <= 1'b0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
            r_dir_up    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_row_mask  <= w_row_mask_nxt;
            r_base_mask <= w_base_mask_nxt;
            r_row_idx   <= w_row_idx_nxt;
            r_width     <= w_width_nxt;
            r_stacked   <= w_stacked_nxt;
            r_game_over <= w_game_over_nxt;
            r_win       <= w_win_nxt;
            r_dir_up    <= w_dir_up_nxt;
        end
    end

    assign row_mask  = r_row_mask;
    assign base_mask = r_base_mask;
    assign row_idx   = r_row_idx;
    assign width     = r_width;
    assign stacked   = r_stacked;
    assign game_over = r_game_over;
    assign win       = r_win;

endmodule

// File: tb/tb_block_row_driver.sv
// Self-checking bench for block_row_driver: directed vector table, corner
// sequences and randomized traffic against a position/width reference model.
module tb_block_row_driver;

    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int MAX_W = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_en = 1'b0;
    logic [7:0] period = 8'd2;
    logic       start = 1'b0;
    logic       drop = 1'b0;
    logic [7:0] row_mask, base_mask;
    logic [1:0] row_idx, width;
    logic       stacked, game_over, win;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    block_row_driver #(.COLS(COLS), .ROWS(ROWS), .MAX_W(MAX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_en   (tick_en),
        .period    (period),
        .start     (start),
        .drop      (drop),
        .row_mask  (row_mask),
        .base_mask (base_mask),
        .row_idx   (row_idx),
        .width     (width),
        .stacked   (stacked),
        .game_over (game_over),
        .win       (win)
    );

    // Reference model: segment described by lowest column and width
    localparam int P_IDLE = 0, P_MOVE = 1, P_CHECK = 2, P_NEXT = 3, P_OVER = 4, P_WIN = 5;
    int m_phase, m_pos, m_w, m_up, m_cnt, m_mask, m_base, m_row, m_stk, m_go, m_win;

    function automatic int seg(input int pos, input int w);
        return ((1 << w) - 1) << pos;
    endfunction

    task automatic mdl_step(input bit st, input bit dr, input bit tk, input int per, input bit rs);
        int ov, p;
        if (!rs) begin
            m_phase = P_IDLE; m_mask = 0; m_base = 'hFF; m_row = 0; m_w = MAX_W;
            m_pos = 0; m_stk = 0; m_go = 0; m_win = 0; m_cnt = 0; m_up = 1;
        end else begin
            m_stk = 0;
            case (m_phase)
                P_IDLE, P_OVER, P_WIN: if (st) begin
                    m_row = 0; m_base = 'hFF; m_w = MAX_W; m_pos = 0; m_mask = seg(0, MAX_W);
                    m_up = 1; m_cnt = 0; m_go = 0; m_win = 0; m_phase = P_MOVE;
                end
                P_MOVE: begin
                    if (dr) m_phase = P_CHECK;
                    else if (tk) begin
                        p = (per == 0) ? 1 : per;
                        if (m_cnt + 1 >= p) begin
                            m_cnt = 0;
                            if (m_w != COLS) begin
                                if (m_up == 1) begin
                                    if (m_pos + m_w == COLS) begin m_up = 0; m_pos = m_pos - 1; end
                                    else m_pos = m_pos + 1;
                                end else begin
                                    if (m_pos == 0) begin m_up = 1; m_pos = m_pos + 1; end
                                    else m_pos = m_pos - 1;
                                end
                                m_mask = seg(m_pos, m_w);
                            end
                        end else m_cnt = m_cnt + 1;
                    end
                end
                P_CHECK: begin
                    ov = m_mask & m_base;
                    if (ov == 0) begin
                        m_go = 1; m_mask = 0; m_phase = P_OVER;
                    end else begin
                        m_mask = ov; m_w = $countones(ov); m_stk = 1;
                        m_pos = 0;
                        while (((ov >> m_pos) & 1) == 0) m_pos = m_pos + 1;
                        if (m_row == ROWS - 1) begin m_win = 1; m_phase = P_WIN; end
                        else m_phase = P_NEXT;
                    end
                end
                P_NEXT: begin
                    m_base = m_mask; m_row = m_row + 1; m_pos = 0; m_mask = seg(0, m_w);
                    m_up = 1; m_cnt = 0; m_phase = P_MOVE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input int e_mask, input int e_base, input int e_idx,
                           input int e_w, input int e_stk, input int e_go, input int e_win);
        chk({tag, ".row_mask"},  int'(row_mask),  e_mask);
        chk({tag, ".base_mask"}, int'(base_mask), e_base);
        chk({tag, ".row_idx"},   int'(row_idx),   e_idx);
        chk({tag, ".width"},     int'(width),     e_w);
        chk({tag, ".stacked"},   int'(stacked),   e_stk);
        chk({tag, ".game_over"}, int'(game_over), e_go);
        chk({tag, ".win"},       int'(win),       e_win);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_mask, m_base, m_row, m_w, m_stk, m_go, m_win);
    endtask

    task automatic cyc(input bit st, input bit dr, input bit tk, input int per, input bit rs = 1'b1);
        start = st; drop = dr; tick_en = tk; period = per[7:0]; rst_n = rs;
        @(posedge clk);
        mdl_step(st, dr, tk, per, rs);
        #1;
    endtask

    typedef struct {
        bit st, dr, tk;
        int per;
        int e_mask, e_base, e_idx, e_w, e_stk, e_go;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit st, input bit dr, input bit tk, input int per, input int mk,
                       input int bs, input int idx, input int w, input int stk, input int go);
        vec_t v;
        v.st = st; v.dr = dr; v.tk = tk; v.per = per;
        v.e_mask = mk; v.e_base = bs; v.e_idx = idx; v.e_w = w; v.e_stk = stk; v.e_go = go;
        tbl.push_back(v);
    endtask

    initial begin
        int sweep[16];
        int n_stk;
        bit rs, st, dr, tk;

        sweep = '{'h38, 'h70, 'h70, 'hE0, 'hE0, 'h70, 'h70, 'h38,
                  'h38, 'h1C, 'h1C, 'h0E, 'h0E, 'h07, 'h07, 'h0E};

        // Row 0 walk, bounce at both edges, then partial drops and a miss
        add(1, 0, 0, 2, 'h07, 'hFF, 0, 3, 0, 0);
        add(0, 0, 1, 2, 'h07, 'hFF, 0, 3, 0, 0);
        add(0, 0, 1, 2, 'h0E, 'hFF, 0, 3, 0, 0);
        add(0, 0, 1, 2, 'h0E, 'hFF, 0, 3, 0, 0);
        add(0, 0, 1, 2, 'h1C, 'hFF, 0, 3, 0, 0);
        add(0, 0, 1, 2, 'h1C, 'hFF, 0, 3, 0, 0);
        add(0, 0, 1, 2, 'h38, 'hFF, 0, 3, 0, 0);
        add(0, 0, 0, 2, 'h38, 'hFF, 0, 3, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 0, 1, 2, sweep[i], 'hFF, 0, 3, 0, 0);
        add(0, 1, 0, 2, 'h0E, 'hFF, 0, 3, 0, 0);
        add(0, 0, 0, 2, 'h0E, 'hFF, 0, 3, 1, 0);
        add(0, 0, 0, 2, 'h07, 'h0E, 1, 3, 0, 0);
        add(1, 0, 1, 2, 'h07, 'h0E, 1, 3, 0, 0);
        add(0, 0, 1, 2, 'h0E, 'h0E, 1, 3, 0, 0);
        add(0, 0, 1, 2, 'h0E, 'h0E, 1, 3, 0, 0);
        add(0, 0, 1, 2, 'h1C, 'h0E, 1, 3, 0, 0);
        add(0, 1, 0, 2, 'h1C, 'h0E, 1, 3, 0, 0);
        add(0, 0, 0, 2, 'h0C, 'h0E, 1, 2, 1, 0);
        add(0, 0, 0, 2, 'h03, 'h0C, 2, 2, 0, 0);
        add(0, 0, 1, 0, 'h06, 'h0C, 2, 2, 0, 0);
        add(0, 0, 1, 0, 'h0C, 'h0C, 2, 2, 0, 0);
        add(0, 0, 1, 1, 'h18, 'h0C, 2, 2, 0, 0);
        add(0, 0, 1, 1, 'h30, 'h0C, 2, 2, 0, 0);
        add(0, 1, 1, 1, 'h30, 'h0C, 2, 2, 0, 0);
        add(0, 0, 0, 1, 'h00, 'h0C, 2, 2, 0, 1);
        add(0, 0, 1, 1, 'h00, 'h0C, 2, 2, 0, 1);
        add(0, 1, 0, 1, 'h00, 'h0C, 2, 2, 0, 1);
        add(1, 0, 0, 2, 'h07, 'hFF, 0, 3, 0, 0);

        // Reset state
        cyc(0, 0, 0, 2, 1'b0);
        cyc(0, 0, 0, 2, 1'b0);
        chk_all("reset", 'h00, 'hFF, 0, 3, 0, 0, 0);
        cyc(0, 0, 0, 2);
        chk_all("idle", 'h00, 'hFF, 0, 3, 0, 0, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].st, tbl[i].dr, tbl[i].tk, tbl[i].per);
            chk_all($sformatf("vec%0d", i), tbl[i].e_mask, tbl[i].e_base, tbl[i].e_idx,
                    tbl[i].e_w, tbl[i].e_stk, tbl[i].e_go, 0);
        end

        // Four aligned drops from a fresh row 0 reach the win state
        n_stk = 0;
        for (int r = 0; r < ROWS; r++) begin
            cyc(0, 1, 0, 2);
            chk_model($sformatf("win_drop%0d", r));
            cyc(0, 0, 0, 2);
            chk_model($sformatf("win_chk%0d", r));
            if (stacked) n_stk++;
            if (r < ROWS - 1) begin
                cyc(0, 0, 0, 2);
                chk_model($sformatf("win_next%0d", r));
            end
        end
        chk("win.stacked_pulses", n_stk, 4);
        chk("win.level", int'(win), 1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1);
        chk_all("win.hold", 'h07, 'h07, 3, 3, 0, 0, 1);

        // Reset asserted while a drop is being checked
        cyc(1, 0, 0, 2);
        cyc(0, 0, 1, 2);
        cyc(0, 1, 0, 2);
        cyc(0, 0, 0, 2, 1'b0);
        chk_all("rst_in_check", 'h00, 'hFF, 0, 3, 0, 0, 0);
        cyc(0, 0, 0, 2, 1'b0);
        chk_all("rst_in_check2", 'h00, 'hFF, 0, 3, 0, 0, 0);
        cyc(0, 0, 1, 2);
        chk_all("rst_release", 'h00, 'hFF, 0, 3, 0, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rs = ($urandom_range(0, 99) != 0);
            st = ($urandom_range(0, 15) == 0);
            dr = ($urandom_range(0, 9) == 0);
            tk = 1'($urandom_range(0, 1));
            cyc(st, dr, tk, int'($urandom_range(0, 3)), rs);
            chk_model($sformatf("rnd%0d", n));
        end

        start = 1'b0; drop = 1'b0; tick_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
